// File: rtl/register_file_if.sv
// Bus bundle between the ID stage register file and its users: one WB write
// port and two combinational read ports (rs, rt).
interface register_file_if;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic [4:0]  ReadReg1;
    logic [4:0]  ReadReg2;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;

    modport master (
        output RegWrite,
        output WriteReg,
        output WriteData,
        output ReadReg1,
        output ReadReg2,
        input  ReadData1,
        input  ReadData2
    );

    modport slave (
        input  RegWrite,
        input  WriteReg,
        input  WriteData,
        input  ReadReg1,
        input  ReadReg2,
        output ReadData1,
        output ReadData2
    );
endinterface

// File: rtl/register_file.sv
// 32 x 32-bit MIPS register file: one write port, two combinational read
// ports, $0 hardwired to zero, optional same-cycle write-to-read forwarding.
module register_file #(
    parameter bit BYPASS = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    register_file_if.slave bus
);

    logic [31:0] regs [31:0];
    logic        write_hit;
    logic [31:0] read_data1;
    logic [31:0] read_data2;

    // A write to $0 is dropped, so entry 0 only ever holds its reset value.
    assign write_hit = bus.RegWrite && (bus.WriteReg != 5'd0);

    // Storage update: asynchronous clear, then one write per rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (write_hit) begin
            regs[bus.WriteReg] <= bus.WriteData;
        end
    end

    // Read port 1: $0 forced to zero, forward the in-flight write on a match.
    always_comb begin
        read_data1 = 32'd0;
        if (bus.ReadReg1 != 5'd0) begin
            if (BYPASS && write_hit && (bus.WriteReg == bus.ReadReg1)) begin
                read_data1 = bus.WriteData;
            end else begin
                read_data1 = regs[bus.ReadReg1];
            end
        end
    end

    // Read port 2: same selection as port 1, evaluated independently.
    always_comb begin
        read_data2 = 32'd0;
        if (bus.ReadReg2 != 5'd0) begin
            if (BYPASS && write_hit && (bus.WriteReg == bus.ReadReg2)) begin
                read_data2 = bus.WriteData;
            end else begin
                read_data2 = regs[bus.ReadReg2];
            end
        end
    end

    assign bus.ReadData1 = read_data1;
    assign bus.ReadData2 = read_data2;

endmodule

// File: tb/tb_register_file.sv
// Directed bench: drives identical stimulus into a forwarding instance (a)
// and a non-forwarding instance (b) and checks both against hand values.
module tb_register_file;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    register_file_if bus_a ();
    register_file_if bus_b ();

    register_file #(.BYPASS(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
    register_file #(.BYPASS(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_in(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                          input logic [4:0] r1, input logic [4:0] r2);
        bus_a.RegWrite = we; bus_a.WriteReg = wr; bus_a.WriteData = wd;
        bus_a.ReadReg1 = r1; bus_a.ReadReg2 = r2;
        bus_b.RegWrite = we; bus_b.WriteReg = wr; bus_b.WriteData = wd;
        bus_b.ReadReg1 = r1; bus_b.ReadReg2 = r2;
    endtask

    task automatic set_we(input logic we);
        bus_a.RegWrite = we;
        bus_b.RegWrite = we;
    endtask

    task automatic do_write(input logic [4:0] wr, input logic [31:0] wd);
        @(negedge clk);
        set_in(1'b1, wr, wd, 5'd0, 5'd0);
        @(posedge clk);
        #1;
        set_we(1'b0);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        set_in(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        do_write(5'd5, 32'hDEADBEEF);
        @(negedge clk);
        set_in(1'b0, 5'd0, 32'd0, 5'd5, 5'd5);
        #1;
        tests++;
        if (bus_b.ReadData1 !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL pre_reset_r5 got %h want %h", bus_b.ReadData1, 32'hDEADBEEF);
        end
        #1;
        rst_n = 1'b0;
        #1;
        tests++;
        if (bus_a.ReadData1 !== 32'd0 || bus_b.ReadData1 !== 32'd0) begin
            fails++;
            $display("FAIL async_reset_r5 got a=%h b=%h want 0", bus_a.ReadData1, bus_b.ReadData1);
        end
        for (int i = 0; i < 32; i++) begin
            set_in(1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i));
            #1;
            tests++;
            if (bus_a.ReadData1 !== 32'd0 || bus_a.ReadData2 !== 32'd0 ||
                bus_b.ReadData1 !== 32'd0 || bus_b.ReadData2 !== 32'd0) begin
                fails++;
                $display("FAIL reset_all_%0d got %h %h %h %h want 0", i, bus_a.ReadData1,
                         bus_a.ReadData2, bus_b.ReadData1, bus_b.ReadData2);
            end
        end
        // Write attempted while reset is held: reset wins.
        @(negedge clk);
        set_in(1'b1, 5'd3, 32'h33333333, 5'd0, 5'd0);
        @(posedge clk);
        #1;
        set_we(1'b0);
        bus_b.ReadReg1 = 5'd3;
        bus_a.ReadReg1 = 5'd3;
        #1;
        tests++;
        if (bus_a.ReadData1 !== 32'd0 || bus_b.ReadData1 !== 32'd0) begin
            fails++;
            $display("FAIL write_during_reset got a=%h b=%h want 0", bus_a.ReadData1, bus_b.ReadData1);
        end
        // Release mid-cycle; the next rising edge performs the write.
        @(negedge clk);
        rst_n = 1'b1;
        set_in(1'b1, 5'd3, 32'h33333333, 5'd3, 5'd3);
        @(posedge clk);
        #1;
        set_we(1'b0);
        #1;
        tests++;
        if (bus_b.ReadData1 !== 32'h33333333) begin
            fails++;
            $display("FAIL first_write_after_release got %h want %h", bus_b.ReadData1, 32'h33333333);
        end
    endtask

    task automatic test_zero_reg;
        @(negedge clk);
        set_in(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        #1;
        tests++;
        if (bus_a.ReadData1 !== 32'd0 || bus_a.ReadData2 !== 32'd0 || bus_b.ReadData1 !== 32'd0) begin
            fails++;
            $display("FAIL zero_during_write got a=%h/%h b=%h want 0", bus_a.ReadData1,
                     bus_a.ReadData2, bus_b.ReadData1);
        end
        @(posedge clk);
        #1;
        set_we(1'b0);
        #1;
        tests++;
        if (bus_a.ReadData1 !== 32'd0 || bus_b.ReadData1 !== 32'd0) begin
            fails++;
            $display("FAIL zero_after_write got a=%h b=%h want 0", bus_a.ReadData1, bus_b.ReadData1);
        end
    endtask

    task automatic test_write_read_all;
        logic [31:0] exp1;
        logic [31:0] exp2;
        for (int i = 1; i < 32; i++) begin
            do_write(5'(i), 32'h10000000 + 32'(i));
        end
        @(negedge clk);
        for (int i = 1; i < 32; i++) begin
            set_in(1'b0, 5'd0, 32'd0, 5'(i), 5'(32 - i));
            exp1 = 32'h10000000 + 32'(i);
            exp2 = 32'h10000000 + 32'(32 - i);
            #1;
            tests++;
            if (bus_a.ReadData1 !== exp1 || bus_a.ReadData2 !== exp2 ||
                bus_b.ReadData1 !== exp1 || bus_b.ReadData2 !== exp2) begin
                fails++;
                $display("FAIL read_pair_%0d got %h %h %h %h want %h %h", i, bus_a.ReadData1,
                         bus_a.ReadData2, bus_b.ReadData1, bus_b.ReadData2, exp1, exp2);
            end
        end
    endtask

    task automatic test_bypass;
        do_write(5'd7, 32'h11111111);
        @(negedge clk);
        set_in(1'b1, 5'd7, 32'h22222222, 5'd7, 5'd7);
        #1;
        tests++;
        if (bus_a.ReadData1 !== 32'h22222222 || bus_a.ReadData2 !== 32'h22222222) begin
            fails++;
            $display("FAIL bypass_before_edge got %h %h want %h", bus_a.ReadData1,
                     bus_a.ReadData2, 32'h22222222);
        end
        tests++;
        if (bus_b.ReadData1 !== 32'h11111111 || bus_b.ReadData2 !== 32'h11111111) begin
            fails++;
            $display("FAIL nobypass_before_edge got %h %h want %h", bus_b.ReadData1,
                     bus_b.ReadData2, 32'h11111111);
        end
        @(posedge clk);
        #1;
        set_we(1'b0);
        #1;
        tests++;
        if (bus_a.ReadData1 !== 32'h22222222 || bus_a.ReadData2 !== 32'h22222222 ||
            bus_b.ReadData1 !== 32'h22222222 || bus_b.ReadData2 !== 32'h22222222) begin
            fails++;
            $display("FAIL bypass_after_edge got %h %h %h %h want %h", bus_a.ReadData1,
                     bus_a.ReadData2, bus_b.ReadData1, bus_b.ReadData2, 32'h22222222);
        end
        // Only the matching port forwards.
        @(negedge clk);
        set_in(1'b1, 5'd8, 32'h88880000, 5'd8, 5'd9);
        #1;
        tests++;
        if (bus_a.ReadData1 !== 32'h88880000 || bus_a.ReadData2 !== 32'h10000009) begin
            fails++;
            $display("FAIL bypass_one_port got %h %h want %h %h", bus_a.ReadData1,
                     bus_a.ReadData2, 32'h88880000, 32'h10000009);
        end
        set_we(1'b0);
        #1;
        tests++;
        if (bus_a.ReadData1 !== 32'h10000008) begin
            fails++;
            $display("FAIL bypass_drop_on_we_low got %h want %h", bus_a.ReadData1, 32'h10000008);
        end
    endtask

    task automatic test_write_suppressed;
        do_write(5'd9, 32'h00000009);
        @(negedge clk);
        set_in(1'b0, 5'd9, 32'hABCD0000, 5'd9, 5'd9);
        #1;
        tests++;
        if (bus_a.ReadData1 !== 32'h00000009 || bus_b.ReadData1 !== 32'h00000009) begin
            fails++;
            $display("FAIL suppressed_before got a=%h b=%h want %h", bus_a.ReadData1,
                     bus_b.ReadData1, 32'h00000009);
        end
        @(posedge clk);
        #1;
        tests++;
        if (bus_a.ReadData2 !== 32'h00000009 || bus_b.ReadData2 !== 32'h00000009) begin
            fails++;
            $display("FAIL suppressed_after got a=%h b=%h want %h", bus_a.ReadData2,
                     bus_b.ReadData2, 32'h00000009);
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        set_in(1'b1, 5'd10, 32'hAAAA0001, 5'd10, 5'd10);
        @(posedge clk);
        #1;
        bus_a.WriteData = 32'hBBBB0002;
        bus_b.WriteData = 32'hBBBB0002;
        #1;
        tests++;
        if (bus_b.ReadData1 !== 32'hAAAA0001) begin
            fails++;
            $display("FAIL b2b_first_edge got %h want %h", bus_b.ReadData1, 32'hAAAA0001);
        end
        @(posedge clk);
        #1;
        set_we(1'b0);
        #1;
        tests++;
        if (bus_a.ReadData1 !== 32'hBBBB0002 || bus_b.ReadData1 !== 32'hBBBB0002) begin
            fails++;
            $display("FAIL b2b_last_wins got a=%h b=%h want %h", bus_a.ReadData1,
                     bus_b.ReadData1, 32'hBBBB0002);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset;
        test_zero_reg;
        test_write_read_all;
        test_bypass;
        test_write_suppressed;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
